// File: rtl/cc_fill_pkg.sv
// Shared types, AXI read-response codes and geometry helpers for the line fill engine.
package cc_fill_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2
    } fill_state_t;

    localparam logic [1:0] RRESP_OKAY   = 2'b00;
    localparam logic [1:0] RRESP_EXOKAY = 2'b01;
    localparam logic [1:0] RRESP_SLVERR = 2'b10;
    localparam logic [1:0] RRESP_DECERR = 2'b11;

    function automatic int fill_log2(input int value);
        int result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

    function automatic int fill_beats(input int line_bytes, input int data_w);
        return (line_bytes * 8) / data_w;
    endfunction

    function automatic int fill_tag_w(input int addr_w, input int idx_w, input int line_bytes);
        return addr_w - idx_w - fill_log2(line_bytes);
    endfunction

    function automatic logic rresp_is_err(input logic [1:0] rresp);
        return (rresp == RRESP_SLVERR) || (rresp == RRESP_DECERR);
    endfunction

endpackage

// File: rtl/cc_beat_deser.sv
// Line buffer for one cache line; beats land at (start + count) mod BEATS so the
// critical word can arrive first while the line is still stored in address order.
module cc_beat_deser
    import cc_fill_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int BEATS  = 8,
    localparam int SLOT_W = fill_log2(BEATS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [SLOT_W-1:0]       start_slot,
    input  logic                    beat_we,
    input  logic [DATA_W-1:0]       beat_data,
    output logic [BEATS*DATA_W-1:0] line,
    output logic [SLOT_W-1:0]       cnt,
    output logic                    last_beat
);

    logic [SLOT_W-1:0] base_reg;
    logic [SLOT_W-1:0] cnt_reg;
    logic [SLOT_W-1:0] wr_slot;

    // SLOT_W-bit addition wraps naturally modulo BEATS
    assign wr_slot   = base_reg + cnt_reg;
    assign cnt       = cnt_reg;
    assign last_beat = (cnt_reg == SLOT_W'(BEATS - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            base_reg <= '0;
            cnt_reg  <= '0;
        end else if (start) begin
            base_reg <= start_slot;
            cnt_reg  <= '0;
        end else if (beat_we) begin
            cnt_reg  <= cnt_reg + 1'b1;
        end
    end

    generate
        for (genvar gi = 0; gi < BEATS; gi++) begin : g_slot
            logic [DATA_W-1:0] slot_reg;
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    slot_reg <= '0;
                end else if (beat_we && (wr_slot == SLOT_W'(gi))) begin
                    slot_reg <= beat_data;
                end
            end
            assign line[gi*DATA_W +: DATA_W] = slot_reg;
        end
    endgenerate

endmodule

// File: rtl/cc_line_fill_engine.sv
// Pops a miss address, collects one AXI read burst into a cache line, forwards the
// critical word, then writes {valid, tag} plus line data to the cache SRAM.
module cc_line_fill_engine
    import cc_fill_pkg::*;
#(
    parameter int DATA_W     = 64,
    parameter int LINE_BYTES = 64,
    parameter int ADDR_W     = 32,
    parameter int IDX_W      = 9,
    localparam int OFF_W     = fill_log2(LINE_BYTES),
    localparam int TAG_W     = fill_tag_w(ADDR_W, IDX_W, LINE_BYTES)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DATA_W-1:0]       mem_rdata_i,
    input  logic [1:0]              mem_rresp_i,
    input  logic                    mem_rlast_i,
    input  logic                    mem_rvalid_i,
    output logic                    mem_rready_o,
    input  logic                    miss_addr_fifo_empty_i,
    input  logic [ADDR_W-1:0]       miss_addr_fifo_rdata_i,
    output logic                    miss_addr_fifo_rden_o,
    output logic                    wren_o,
    input  logic                    wready_i,
    output logic [IDX_W-1:0]        waddr_o,
    output logic [TAG_W:0]          wdata_tag_o,
    output logic [LINE_BYTES*8-1:0] wdata_data_o,
    output logic                    cw_valid_o,
    output logic [DATA_W-1:0]       cw_data_o,
    output logic                    fill_err_o
);

    localparam int BEATS  = fill_beats(LINE_BYTES, DATA_W);
    localparam int BOFF_W = fill_log2(DATA_W / 8);
    localparam int SLOT_W = fill_log2(BEATS);

    fill_state_t       state_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic [TAG_W-1:0]  tag_reg;
    logic              err_reg;
    logic              wren_reg;
    logic [TAG_W:0]    wtag_reg;
    logic              cw_valid_reg;
    logic [DATA_W-1:0] cw_data_reg;
    logic              fill_err_reg;

    logic              pop;
    logic              beat_hs;
    logic              rlast_bad;
    logic              err_next;
    logic [SLOT_W-1:0] cnt;
    logic              last_beat;
    logic              unused_byte_offset;

    assign pop       = (state_reg == ST_IDLE) && !miss_addr_fifo_empty_i;
    assign beat_hs   = (state_reg == ST_FILL) && mem_rvalid_i;
    // rlast must coincide exactly with the final counted beat
    assign rlast_bad = (last_beat != mem_rlast_i);
    assign err_next  = err_reg | rresp_is_err(mem_rresp_i) | rlast_bad;

    assign unused_byte_offset = ^miss_addr_fifo_rdata_i[BOFF_W-1:0];

    cc_beat_deser #(
        .DATA_W (DATA_W),
        .BEATS  (BEATS)
    ) u_deser (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (pop),
        .start_slot (miss_addr_fifo_rdata_i[OFF_W-1:BOFF_W]),
        .beat_we    (beat_hs),
        .beat_data  (mem_rdata_i),
        .line       (wdata_data_o),
        .cnt        (cnt),
        .last_beat  (last_beat)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            idx_reg      <= '0;
            tag_reg      <= '0;
            err_reg      <= 1'b0;
            wren_reg     <= 1'b0;
            wtag_reg     <= '0;
            cw_valid_reg <= 1'b0;
            cw_data_reg  <= '0;
            fill_err_reg <= 1'b0;
        end else begin
            cw_valid_reg <= 1'b0;
            fill_err_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (pop) begin
                        idx_reg   <= miss_addr_fifo_rdata_i[OFF_W+IDX_W-1:OFF_W];
                        tag_reg   <= miss_addr_fifo_rdata_i[ADDR_W-1:OFF_W+IDX_W];
                        err_reg   <= 1'b0;
                        state_reg <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (beat_hs) begin
                        if (cnt == '0) begin
                            cw_valid_reg <= 1'b1;
                            cw_data_reg  <= mem_rdata_i;
                        end
                        err_reg <= err_next;
                        if (last_beat || mem_rlast_i) begin
                            wren_reg  <= 1'b1;
                            wtag_reg  <= {~err_next, tag_reg};
                            state_reg <= ST_WRITE;
                        end
                    end
                end
                ST_WRITE: begin
                    if (wready_i) begin
                        wren_reg     <= 1'b0;
                        fill_err_reg <= err_reg;
                        state_reg    <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign miss_addr_fifo_rden_o = pop;
    assign mem_rready_o          = (state_reg == ST_FILL);
    assign wren_o                = wren_reg;
    assign waddr_o               = idx_reg;
    assign wdata_tag_o           = wtag_reg;
    assign cw_valid_o            = cw_valid_reg;
    assign cw_data_o             = cw_data_reg;
    assign fill_err_o            = fill_err_reg;

endmodule
